// File: rtl/lc3_mem_io_unit_if.sv
// External word-memory handshake between the LC-3 memory/IO stage (master)
// and the memory model or controller (slave).
interface lc3_mem_io_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lc3_mem_io_unit.sv
// LC-3 memory/IO stage: owns MAR/MDR, decodes the keyboard/display device
// registers and runs the req/ack handshake to external word memory.
//
// state | meaning
// IDLE  | waiting for MIO_EN; MAR/R_W latched for the access on trigger
// IO    | one-cycle device register access
// MREQ  | mem_req held until mem_ack
// DONE  | R pulsed; wait for control to drop MIO_EN
module lc3_mem_io_unit #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic                      clk,
  input  logic                      rst_n,
  inout  wire  [15:0]               BUS,
  input  logic                      LD_MAR,
  input  logic                      LD_MDR,
  input  logic                      GateMDR,
  input  logic                      MIO_EN,
  input  logic                      R_W,
  output logic                      R,
  lc3_mem_io_unit_if.master         mem,
  input  logic                      kbd_valid,
  input  logic [7:0]                kbd_data,
  output logic                      ddr_valid,
  output logic [7:0]                ddr_data,
  input  logic                      ddr_ready,
  output logic                      KBD_INT,
  output logic                      DSP_INT
);

  typedef enum logic [1:0] {IDLE, IO, MREQ, DONE} state_t;

  state_t      state;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] acc_addr;
  logic        acc_we;
  logic        kbsr_rdy;
  logic        kbsr_ie;
  logic [7:0]  kbdr;
  logic        dsr_rdy;
  logic        dsr_ie;
  logic [7:0]  ddr;
  logic [15:0] dev_rdata;
  logic        dev_hit;
  logic        io_wr;
  logic        io_rd_kbdr;

  assign BUS = GateMDR ? mdr : 16'hzzzz;

  assign mem.mem_addr  = acc_addr;
  assign mem.mem_wdata = mdr;

  assign dev_hit    = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                      (mar == DSR_ADDR)  || (mar == DDR_ADDR);
  assign io_wr      = (state == IO) && acc_we;
  assign io_rd_kbdr = (state == IO) && !acc_we && (acc_addr == KBDR_ADDR);

  assign ddr_data = ddr;
  assign KBD_INT  = kbsr_rdy & kbsr_ie;
  assign DSP_INT  = dsr_rdy & dsr_ie;

  always_comb begin
    dev_rdata = 16'h0000;
    case (acc_addr)
      KBSR_ADDR: dev_rdata = {kbsr_rdy, kbsr_ie, 14'b0};
      KBDR_ADDR: dev_rdata = {8'h00, kbdr};
      DSR_ADDR:  dev_rdata = {dsr_rdy, dsr_ie, 14'b0};
      default:   dev_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mar         <= 16'h0000;
      mdr         <= 16'h0000;
      acc_addr    <= 16'h0000;
      acc_we      <= 1'b0;
      R           <= 1'b0;
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
    end else begin
      R <= 1'b0;
      if (LD_MAR) mar <= BUS;
      if (LD_MDR && !MIO_EN) mdr <= BUS;
      case (state)
        IDLE: begin
          if (MIO_EN && !R) begin
            acc_addr <= mar;
            acc_we   <= R_W;
            if (dev_hit) begin
              state <= IO;
            end else begin
              state       <= MREQ;
              mem.mem_req <= 1'b1;
              mem.mem_we  <= R_W;
            end
          end
        end
        IO: begin
          if (!acc_we) mdr <= dev_rdata;
          R     <= 1'b1;
          state <= DONE;
        end
        MREQ: begin
          if (mem.mem_ack) begin
            if (!acc_we) mdr <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            R           <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (!MIO_EN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A char arriving in the same cycle as a KBDR read refills the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsr_rdy  <= 1'b0;
      kbsr_ie   <= 1'b0;
      kbdr      <= 8'h00;
      dsr_rdy   <= 1'b1;
      dsr_ie    <= 1'b0;
      ddr       <= 8'h00;
      ddr_valid <= 1'b0;
    end else begin
      if (io_wr && (acc_addr == KBSR_ADDR)) kbsr_ie <= mdr[14];
      if (io_wr && (acc_addr == DSR_ADDR))  dsr_ie  <= mdr[14];

      if (kbd_valid && (!kbsr_rdy || io_rd_kbdr)) begin
        kbdr     <= kbd_data;
        kbsr_rdy <= 1'b1;
      end else if (io_rd_kbdr) begin
        kbsr_rdy <= 1'b0;
      end

      if (io_wr && (acc_addr == DDR_ADDR)) begin
        ddr       <= mdr[7:0];
        dsr_rdy   <= 1'b0;
        ddr_valid <= 1'b1;
      end else if (ddr_valid && ddr_ready) begin
        ddr_valid <= 1'b0;
        dsr_rdy   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_io_unit.sv
// Scoreboard bench for lc3_mem_io_unit: directed device/memory scenarios then
// randomized accesses against a behavioural memory and device model.
module tb_lc3_mem_io_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LD_MAR, LD_MDR, GateMDR, MIO_EN, R_W;
  logic        R;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        ddr_valid;
  logic [7:0]  ddr_data;
  logic        ddr_ready;
  logic        KBD_INT, DSP_INT;
  logic [15:0] tb_bus;
  logic        tb_bus_en;
  wire  [15:0] bus;

  assign bus = tb_bus_en ? tb_bus : 16'hzzzz;

  lc3_mem_io_unit_if mif ();

  lc3_mem_io_unit dut (
    .clk(clk), .rst_n(rst_n), .BUS(bus),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .GateMDR(GateMDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .R(R), .mem(mif.master),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .ddr_valid(ddr_valid), .ddr_data(ddr_data), .ddr_ready(ddr_ready),
    .KBD_INT(KBD_INT), .DSP_INT(DSP_INT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          r_count = 0;
  int          exp_r = 0;
  int          fixed_delay = -1;
  bit          hold_ack = 1'b0;

  req_t        mreq_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  disp_q[$];

  logic [15:0] ext_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  // reference model state
  bit          kb_full, kb_ie, dsp_ready, dsp_ie, ddr_val;
  logic [7:0]  kb_char;
  logic [15:0] ref_mdr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_mem_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic bit is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  task automatic ref_reset();
    kb_full = 0; kb_ie = 0; kb_char = 8'h00;
    dsp_ready = 1; dsp_ie = 0; ddr_val = 0;
    disp_q.delete();
    ref_mdr = 16'h0000;
  endtask

  task automatic dev_op(input logic [15:0] a, input logic we, input logic [15:0] d,
                        output logic [15:0] rdata);
    rdata = d;
    if (we) begin
      case (a)
        16'hFE00: kb_ie = d[14];
        16'hFE04: dsp_ie = d[14];
        16'hFE06: begin
          disp_q.delete();
          disp_q.push_back(d[7:0]);
          ddr_val = 1; dsp_ready = 0;
        end
        default: ;
      endcase
    end else begin
      case (a)
        16'hFE00: rdata = {kb_full, kb_ie, 14'b0};
        16'hFE02: begin rdata = {8'h00, kb_char}; kb_full = 0; end
        16'hFE04: rdata = {dsp_ready, dsp_ie, 14'b0};
        default:  rdata = 16'h0000;
      endcase
    end
  endtask

  task automatic post_checks();
    chk("kbd_int", KBD_INT, kb_full & kb_ie);
    chk("dsp_int", DSP_INT, dsp_ready & dsp_ie);
    chk("ddr_valid", ddr_valid, ddr_val);
    if (ddr_val) chk("ddr_data", ddr_data, disp_q[0]);
  endtask

  // external memory: ack after a random (or fixed) number of cycles
  initial begin
    int cnt = -1;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        else if (cnt == 0 && !hold_ack) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = ext_mem.exists(mif.mem_addr) ? ext_mem[mif.mem_addr] : init_val(mif.mem_addr);
          if (mif.mem_we) ext_mem[mif.mem_addr] = mif.mem_wdata;
          cnt = -1;
        end else if (cnt > 0) cnt--;
      end else cnt = -1;
    end
  end

  // monitor / scoreboard
  bit   prev_r = 0, prev_ack = 0, prev_req = 0, cur_ok = 0;
  req_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_r = 0; prev_ack = 0; prev_req = 0; cur_ok = 0;
    end else begin
      if (prev_ack) chk("r_after_ack", R, 1);
      if (prev_r) chk("r_single_pulse", R, 0);
      if (R && !prev_r) r_count++;
      if (prev_req && !mif.mem_req) chk("req_held_until_ack", prev_ack, 1);
      if (mif.mem_req && !prev_req) begin
        if (mreq_q.size() == 0) begin
          chk("unexpected_mem_req", mif.mem_req, 0);
          cur_ok = 0;
        end else begin
          cur = mreq_q.pop_front();
          cur_ok = 1;
        end
      end
      if (mif.mem_req && cur_ok) begin
        chk("mem_addr", mif.mem_addr, cur.addr);
        chk("mem_we", mif.mem_we, cur.we);
        chk("mem_wdata", mif.mem_wdata, cur.wdata);
      end
      if (GateMDR) begin
        if (rd_q.size() == 0) chk("unexpected_gate", GateMDR, 0);
        else chk("mdr_on_bus", bus, rd_q.pop_front());
      end
      if (ddr_valid && ddr_ready) begin
        if (disp_q.size() == 0) chk("unexpected_ddr_accept", ddr_valid, 0);
        else chk("ddr_accept_data", ddr_data, disp_q.pop_front());
      end
      prev_r = R; prev_ack = mif.mem_ack; prev_req = mif.mem_req;
    end
  end

  task automatic load_mar(input logic [15:0] a);
    @(posedge clk); #1;
    tb_bus_en = 1; tb_bus = a; LD_MAR = 1;
    @(posedge clk); #1;
    LD_MAR = 0; tb_bus_en = 0;
  endtask

  task automatic access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                        input int hold, input bit kbd_same, input logic [7:0] ch,
                        input bit noise);
    logic [15:0] expv;
    bit          dev, full_before, seen;
    int          cyc;
    load_mar(a);
    if (we) begin
      tb_bus_en = 1; tb_bus = wd; LD_MDR = 1;
      @(posedge clk); #1;
      LD_MDR = 0; tb_bus_en = 0;
      ref_mdr = wd;
    end
    dev = is_dev(a);
    full_before = kb_full;
    if (dev) begin
      dev_op(a, we, ref_mdr, expv);
    end else begin
      mreq_q.push_back('{addr: a, we: we, wdata: ref_mdr});
      if (we) begin ref_mem[a] = ref_mdr; expv = ref_mdr; end
      else expv = ref_mem_rd(a);
    end
    if (kbd_same && (!full_before || (a == 16'hFE02 && !we))) begin
      kb_char = ch; kb_full = 1;
    end
    ref_mdr = expv;
    exp_r++;
    MIO_EN = 1; R_W = we;
    seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      kbd_valid = 0; LD_MDR = 0; LD_MAR = 0; tb_bus_en = 0;
      if (R) begin seen = 1; break; end
      if (cyc == 1) begin
        if (kbd_same) begin kbd_valid = 1; kbd_data = ch; end
        if (noise) begin
          tb_bus_en = 1; tb_bus = 16'($urandom); LD_MDR = 1; LD_MAR = 1;
        end
      end
    end
    if (!seen) chk("r_timeout", R, 1);
    else if (dev) chk("dev_latency", cyc, 2);
    repeat ((hold >= 0) ? hold : int'($urandom_range(0, 4))) begin
      @(posedge clk); #1;
    end
    MIO_EN = 0; R_W = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("r_count", r_count, exp_r);
    GateMDR = 1;
    rd_q.push_back(expv);
    @(posedge clk); #1;
    GateMDR = 0;
    post_checks();
  endtask

  task automatic kbd_strobe(input logic [7:0] ch);
    @(posedge clk); #1;
    kbd_valid = 1; kbd_data = ch;
    @(posedge clk); #1;
    kbd_valid = 0;
    if (!kb_full) begin kb_char = ch; kb_full = 1; end
    post_checks();
  endtask

  task automatic dsp_accept();
    @(posedge clk); #1;
    ddr_ready = 1;
    @(posedge clk); #1;
    ddr_ready = 0;
    if (ddr_val) begin ddr_val = 0; dsp_ready = 1; end
    post_checks();
  endtask

  initial begin
    logic [15:0] a;
    int          op;
    bit          got;
    rst_n = 0;
    LD_MAR = 0; LD_MDR = 0; GateMDR = 0; MIO_EN = 0; R_W = 0;
    kbd_valid = 0; kbd_data = 8'h00; ddr_ready = 0;
    tb_bus = 16'h0000; tb_bus_en = 0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r", R, 0);
    chk("reset_mem_req", mif.mem_req, 0);
    chk("reset_mem_we", mif.mem_we, 0);
    rst_n = 1;
    post_checks();

    // memory write then read
    ext_mem[16'h3001] = 16'hABCD;
    ref_mem[16'h3001] = 16'hABCD;
    fixed_delay = 2;
    access(16'h3000, 1, 16'h1234, -1, 0, 8'h00, 0);
    fixed_delay = -1;
    access(16'h3001, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'h3000, 0, 16'h0000, -1, 0, 8'h00, 0);

    // keyboard
    access(16'hFE04, 0, 16'h0000, -1, 0, 8'h00, 0);
    kbd_strobe(8'h41);
    access(16'hFE00, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'hFE02, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'hFE00, 0, 16'h0000, -1, 0, 8'h00, 0);
    kbd_strobe(8'h42);
    kbd_strobe(8'h43);
    access(16'hFE02, 0, 16'h0000, -1, 0, 8'h00, 0);

    // display
    access(16'hFE06, 1, 16'h0058, -1, 0, 8'h00, 0);
    access(16'hFE04, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'hFE06, 0, 16'h0000, -1, 0, 8'h00, 0);
    dsp_accept();
    access(16'hFE04, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'hFE06, 1, 16'h0061, -1, 0, 8'h00, 0);
    access(16'hFE06, 1, 16'h0062, -1, 0, 8'h00, 0);
    dsp_accept();

    // interrupts, long MIO_EN hold
    access(16'hFE00, 1, 16'h4000, -1, 0, 8'h00, 0);
    kbd_strobe(8'h55);
    access(16'hFE02, 0, 16'h0000, 5, 0, 8'h00, 0);
    access(16'hFE04, 1, 16'h4000, -1, 0, 8'h00, 0);

    // KBDR read coinciding with a new char
    kbd_strobe(8'h66);
    access(16'hFE02, 0, 16'h0000, -1, 1, 8'h77, 0);
    access(16'hFE02, 0, 16'h0000, -1, 0, 8'h00, 0);

    // LD_MAR/LD_MDR during an access must not disturb it
    access(16'h3010, 1, 16'hBEEF, -1, 0, 8'h00, 1);
    access(16'h3010, 0, 16'h0000, -1, 0, 8'h00, 1);
    access(16'hFE06, 1, 16'h0033, -1, 0, 8'h00, 1);
    dsp_accept();

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3 || op == 9) begin
        case ($urandom_range(0, 5))
          0: a = 16'hFE01;
          1: a = 16'hFE08;
          2: a = 16'hFFFE;
          default: a = 16'h3100 | 16'($urandom_range(0, 15));
        endcase
        access(a, 1'($urandom_range(0, 1)), 16'($urandom), -1, op == 9,
               8'($urandom), $urandom_range(0, 2) == 0);
      end else if (op <= 6) begin
        a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
        access(a, 1'($urandom_range(0, 1)), 16'($urandom), -1,
               $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
      end else if (op == 7) begin
        kbd_strobe(8'($urandom));
      end else begin
        dsp_accept();
      end
    end

    // reset in the middle of a memory access
    access(16'hFE06, 1, 16'h0044, -1, 0, 8'h00, 0);
    hold_ack = 1;
    load_mar(16'h3200);
    mreq_q.push_back('{addr: 16'h3200, we: 1'b0, wdata: ref_mdr});
    MIO_EN = 1; R_W = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mif.mem_req) begin got = 1; break; end
    end
    chk("mreq_before_reset", mif.mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("async_mem_req_drop", mif.mem_req, 0);
    chk("async_r_low", R, 0);
    MIO_EN = 0;
    @(posedge clk); #1;
    rst_n = 1;
    hold_ack = 0;
    mreq_q.delete();
    ref_reset();
    post_checks();
    access(16'hFE04, 0, 16'h0000, -1, 0, 8'h00, 0);
    access(16'h3200, 1, 16'h5678, -1, 0, 8'h00, 0);
    access(16'h3200, 0, 16'h0000, -1, 0, 8'h00, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
